// File: rtl/div_8by4.sv
// Sequential restoring unsigned divider: DIVIDEND_W-bit dividend by DIVISOR_W-bit divisor,
// one quotient bit per clock, with the en_i start / fim_o done handshake.
module div_8by4 #(
  parameter int DIVIDEND_W = 8,
  parameter int DIVISOR_W  = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  en_i,
  input  logic [DIVIDEND_W-1:0] A_i,
  input  logic [DIVISOR_W-1:0]  B_i,
  output logic [DIVIDEND_W-1:0] Q_o,
  output logic [DIVISOR_W-1:0]  R_o,
  output logic                  div0_o,
  output logic                  fim_o
);

  localparam int CNT_W = $clog2(DIVIDEND_W) + 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_END  = 2'd2;

  logic [1:0]            r_state;
  logic [DIVIDEND_W-1:0] r_dvd;
  logic [DIVISOR_W-1:0]  r_dvs;
  logic [DIVISOR_W:0]    r_rem;
  logic [CNT_W-1:0]      r_cnt;

  logic [DIVISOR_W:0]    w_t;
  logic [DIVISOR_W:0]    w_diff;
  logic                  w_ge;
  logic [DIVISOR_W:0]    w_rem_nxt;
  logic [DIVIDEND_W-1:0] w_dvd_nxt;
  logic                  w_last;

  // One restoring step: shift in the next dividend bit, subtract when it fits.
  assign w_t       = {r_rem[DIVISOR_W-1:0], r_dvd[DIVIDEND_W-1]};
  assign w_ge      = (w_t >= {1'b0, r_dvs});
  assign w_diff    = w_t - {1'b0, r_dvs};
  assign w_rem_nxt = w_ge ? w_diff : w_t;
  assign w_dvd_nxt = {r_dvd[DIVIDEND_W-2:0], w_ge};
  assign w_last    = (r_cnt == CNT_W'(DIVIDEND_W - 1));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= ST_IDLE;
      r_dvd   <= '0;
      r_dvs   <= '0;
      r_rem   <= '0;
      r_cnt   <= '0;
      Q_o     <= '0;
      R_o     <= '0;
      div0_o  <= 1'b0;
      fim_o   <= 1'b0;
    end else begin
      fim_o <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (en_i) begin
            if (B_i == '0) begin
              Q_o     <= '1;
              R_o     <= '0;
              div0_o  <= 1'b1;
              fim_o   <= 1'b1;
              r_state <= ST_END;
            end else begin
              r_dvd   <= A_i;
              r_dvs   <= B_i;
              r_rem   <= '0;
              r_cnt   <= '0;
              r_state <= ST_CALC;
            end
          end
        end
        ST_CALC: begin
          r_dvd <= w_dvd_nxt;
          r_rem <= w_rem_nxt;
          r_cnt <= r_cnt + 1'b1;
          if (w_last) begin
            Q_o     <= w_dvd_nxt;
            R_o     <= w_rem_nxt[DIVISOR_W-1:0];
            div0_o  <= 1'b0;
            fim_o   <= 1'b1;
            r_state <= ST_END;
          end
        end
        ST_END: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_8by4.sv
// Scoreboard bench for div_8by4: directed vectors plus an exhaustive sweep, with a
// monitor that checks result, done latency, single-cycle fim_o and output hold.
module tb_div_8by4;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic       en_i  = 1'b0;
  logic [7:0] A_i   = '0;
  logic [3:0] B_i   = '0;
  logic [7:0] Q_o;
  logic [3:0] R_o;
  logic       div0_o;
  logic       fim_o;

  div_8by4 dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .en_i  (en_i),
    .A_i   (A_i),
    .B_i   (B_i),
    .Q_o   (Q_o),
    .R_o   (R_o),
    .div0_o(div0_o),
    .fim_o (fim_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [7:0] q;
    logic [3:0] r;
    logic       d0;
    int         start;
    int         lat;
  } exp_t;

  exp_t       sb[$];
  int         cyc = 0;
  int         n_vec = 0;
  int         n_err = 0;
  logic       prev_fim = 1'b0;
  logic [7:0] held_q = '0;
  logic [3:0] held_r = '0;
  logic       held_d0 = 1'b0;

  always @(posedge clk_i) cyc <= cyc + 1;

  // Monitor: pops an expectation whenever the DUT reports done.
  always @(negedge clk_i) begin
    if (!rst_i) begin
      if (fim_o) begin
        if (prev_fim) begin
          n_vec++; n_err++;
          $display("FAIL fim_width: fim_o high two cycles in a row at cycle %0d, required one", cyc);
        end
        if (sb.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL spurious_fim: fim_o=1 at cycle %0d, required 0 (no operation pending)", cyc);
        end else begin
          exp_t e;
          e = sb.pop_front();
          n_vec++;
          if (Q_o !== e.q || R_o !== e.r || div0_o !== e.d0) begin
            n_err++;
            $display("FAIL result: got Q=%0d R=%0d div0=%0b, required Q=%0d R=%0d div0=%0b",
                     Q_o, R_o, div0_o, e.q, e.r, e.d0);
          end
          n_vec++;
          if (cyc - e.start != e.lat) begin
            n_err++;
            $display("FAIL latency: got %0d cycles, required %0d", cyc - e.start, e.lat);
          end
          held_q  = e.q;
          held_r  = e.r;
          held_d0 = e.d0;
        end
      end else begin
        n_vec++;
        if (Q_o !== held_q || R_o !== held_r || div0_o !== held_d0) begin
          n_err++;
          $display("FAIL hold: at cycle %0d got Q=%0d R=%0d div0=%0b, required Q=%0d R=%0d div0=%0b",
                   cyc, Q_o, R_o, div0_o, held_q, held_r, held_d0);
        end
        if (sb.size() != 0 && cyc - sb[0].start > sb[0].lat + 1) begin
          n_vec++; n_err++;
          $display("FAIL timeout: no fim_o by cycle %0d, required at %0d", cyc, sb[0].start + sb[0].lat);
          void'(sb.pop_front());
        end
      end
    end
    prev_fim = fim_o;
  end

  task automatic push_exp(input logic [7:0] q, input logic [3:0] r, input logic d0,
                          input int start, input int lat);
    exp_t e;
    e.q = q; e.r = r; e.d0 = d0; e.start = start; e.lat = lat;
    sb.push_back(e);
  endtask

  // Issue one operation from IDLE and return at a negedge with the DUT back in IDLE.
  task automatic run(input logic [7:0] a, input logic [3:0] b,
                     input logic [7:0] q, input logic [3:0] r, input logic d0);
    int lat;
    lat = d0 ? 0 : 8;
    @(negedge clk_i);
    A_i = a; B_i = b; en_i = 1'b1;
    push_exp(q, r, d0, cyc + 1, lat);
    @(negedge clk_i);
    en_i = 1'b0;
    repeat (lat + 1) @(negedge clk_i);
  endtask

  task automatic check_zero(input string name);
    n_vec++;
    if (Q_o !== 8'd0 || R_o !== 4'd0 || div0_o !== 1'b0 || fim_o !== 1'b0) begin
      n_err++;
      $display("FAIL %s: got Q=%0d R=%0d div0=%0b fim=%0b, required all 0",
               name, Q_o, R_o, div0_o, fim_o);
    end
  endtask

  initial begin
    int e0;
    logic [7:0] mq;
    logic [3:0] mr;

    #12 check_zero("reset_state");
    @(negedge clk_i);
    rst_i = 1'b0;

    run(8'd200, 4'd7,  8'd28,  4'd4, 1'b0);
    run(8'd255, 4'd1,  8'd255, 4'd0, 1'b0);
    run(8'd255, 4'd15, 8'd17,  4'd0, 1'b0);
    run(8'd5,   4'd9,  8'd0,   4'd5, 1'b0);
    run(8'd0,   4'd3,  8'd0,   4'd0, 1'b0);
    run(8'd100, 4'd0,  8'd255, 4'd0, 1'b1);
    run(8'd9,   4'd2,  8'd4,   4'd1, 1'b0);

    // Operand changes and an en_i pulse mid-calculation must be ignored.
    @(negedge clk_i);
    A_i = 8'd200; B_i = 4'd7; en_i = 1'b1;
    push_exp(8'd28, 4'd4, 1'b0, cyc + 1, 8);
    @(negedge clk_i);
    en_i = 1'b0;
    repeat (3) @(negedge clk_i);
    A_i = 8'd5; B_i = 4'd0; en_i = 1'b1;
    @(negedge clk_i);
    A_i = 8'd77; B_i = 4'd6; en_i = 1'b0;
    repeat (8) @(negedge clk_i);

    // en_i held high: a new start every 10 cycles.
    @(negedge clk_i);
    A_i = 8'd9; B_i = 4'd2; en_i = 1'b1;
    e0 = cyc + 1;
    for (int k = 0; k < 3; k++) push_exp(8'd4, 4'd1, 1'b0, e0 + 10 * k, 8);
    repeat (21) @(negedge clk_i);
    en_i = 1'b0;
    repeat (9) @(negedge clk_i);

    // Asynchronous reset between edges during iteration 4 aborts the operation.
    @(negedge clk_i);
    A_i = 8'd200; B_i = 4'd7; en_i = 1'b1;
    @(negedge clk_i);
    en_i = 1'b0;
    repeat (3) @(negedge clk_i);
    @(posedge clk_i);
    #2 rst_i = 1'b1;
    held_q = '0; held_r = '0; held_d0 = 1'b0;
    #1 check_zero("async_reset");
    @(negedge clk_i);
    rst_i = 1'b0;
    repeat (12) @(negedge clk_i);
    run(8'd77, 4'd6, 8'd12, 4'd5, 1'b0);

    // Exhaustive sweep against a reference model.
    for (int a = 0; a < 256; a++) begin
      for (int b = 0; b < 16; b++) begin
        if (b == 0) begin
          mq = 8'hFF; mr = 4'd0;
        end else begin
          mq = 8'(a / b); mr = 4'(a % b);
        end
        run(8'(a), 4'(b), mq, mr, (b == 0));
      end
    end

    repeat (5) @(negedge clk_i);
    n_vec++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d operations still pending, required 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
